// File: rtl/mem_port_arbiter_if.sv
// Bundle of fetch, data and RAM-side signals shared by the unified-memory arbiter.
// The slave modport is the arbiter's view; master is the pipeline/RAM side.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic                  if_req;
  logic [ADDR_W-1:0]     if_addr;
  logic                  if_kill;
  logic [DATA_W-1:0]     if_rdata;
  logic                  if_ready;
  logic                  if_stall;

  logic                  mem_req;
  logic                  mem_we;
  logic [ADDR_W-1:0]     mem_addr;
  logic [DATA_W-1:0]     mem_wdata;
  logic [DATA_W/8-1:0]   mem_wstrb;
  logic [DATA_W-1:0]     mem_rdata;
  logic                  mem_ready;
  logic                  mem_stall;

  logic                  ram_en;
  logic                  ram_we;
  logic [ADDR_W-1:0]     ram_addr;
  logic [DATA_W-1:0]     ram_wdata;
  logic [DATA_W/8-1:0]   ram_wstrb;
  logic [DATA_W-1:0]     ram_rdata;

  modport slave (
    input  if_req, if_addr, if_kill,
    output if_rdata, if_ready, if_stall,
    input  mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
    output mem_rdata, mem_ready, mem_stall,
    output ram_en, ram_we, ram_addr, ram_wdata, ram_wstrb,
    input  ram_rdata
  );

  modport master (
    output if_req, if_addr, if_kill,
    input  if_rdata, if_ready, if_stall,
    output mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
    input  mem_rdata, mem_ready, mem_stall,
    input  ram_en, ram_we, ram_addr, ram_wdata, ram_wstrb,
    output ram_rdata
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Arbitrates a single-port fixed-latency unified memory between fetch (IF) and
// load/store (MEM) ports: data priority with a starvation guard for fetch.
module mem_port_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int MEM_LAT    = 1,
  parameter int STARVE_MAX = 4
) (
  input  logic               clk,
  input  logic               rst,
  mem_port_arbiter_if.slave  bus
);
  localparam int STRB_W = DATA_W / 8;
  localparam int CNT_W  = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam int SC_W   = $clog2(STARVE_MAX + 1);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;
  typedef enum logic {OWN_IF, OWN_MEM} owner_t;

  state_t              r_state;
  state_t              w_state_nxt;
  owner_t              r_owner;
  logic                r_kill_flag;
  logic [CNT_W-1:0]    r_wait_cnt;
  logic [SC_W-1:0]     r_starve_cnt;
  logic                r_ram_en;
  logic                r_ram_we;
  logic [ADDR_W-1:0]   r_ram_addr;
  logic [DATA_W-1:0]   r_ram_wdata;
  logic [STRB_W-1:0]   r_ram_wstrb;
  logic [DATA_W-1:0]   r_if_rdata;
  logic [DATA_W-1:0]   r_mem_rdata;

  logic                w_grant_if;
  logic                w_grant_mem;
  logic                w_capture;
  logic                w_kill_hit;
  logic                w_starved;

  assign w_starved  = (r_starve_cnt == SC_W'(STARVE_MAX));
  assign w_kill_hit = bus.if_kill && (r_owner == OWN_IF) && (r_state != S_IDLE);

  always_comb begin
    w_state_nxt = r_state;
    w_grant_if  = 1'b0;
    w_grant_mem = 1'b0;
    w_capture   = 1'b0;
    case (r_state)
      S_IDLE: begin
        // A fetch being killed in this same cycle is not eligible for a grant
        if (bus.if_req && !bus.if_kill && (!bus.mem_req || w_starved)) begin
          w_grant_if  = 1'b1;
          w_state_nxt = S_ISSUE;
        end else if (bus.mem_req) begin
          w_grant_mem = 1'b1;
          w_state_nxt = S_ISSUE;
        end
      end
      S_ISSUE: w_state_nxt = S_WAIT;
      S_WAIT: begin
        if (r_wait_cnt == '0) begin
          w_capture   = 1'b1;
          w_state_nxt = S_RESP;
        end
      end
      S_RESP:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_owner      <= OWN_IF;
      r_kill_flag  <= 1'b0;
      r_wait_cnt   <= '0;
      r_starve_cnt <= '0;
      r_ram_en     <= 1'b0;
      r_ram_we     <= 1'b0;
      r_ram_addr   <= '0;
      r_ram_wdata  <= '0;
      r_ram_wstrb  <= '0;
      r_if_rdata   <= '0;
      r_mem_rdata  <= '0;
    end else begin
      r_ram_en <= 1'b0;
      r_ram_we <= 1'b0;
      if (w_grant_if) begin
        r_owner      <= OWN_IF;
        r_ram_en     <= 1'b1;
        r_ram_addr   <= bus.if_addr;
        r_ram_wstrb  <= '0;
        r_starve_cnt <= '0;
      end
      if (w_grant_mem) begin
        r_owner     <= OWN_MEM;
        r_ram_en    <= 1'b1;
        r_ram_we    <= bus.mem_we;
        r_ram_addr  <= bus.mem_addr;
        r_ram_wdata <= bus.mem_wdata;
        r_ram_wstrb <= bus.mem_we ? bus.mem_wstrb : '0;
        if (!bus.if_req)     r_starve_cnt <= '0;
        else if (!w_starved) r_starve_cnt <= r_starve_cnt + 1'b1;
      end
      if (r_state == S_ISSUE) r_wait_cnt <= CNT_W'(MEM_LAT - 1);
      else if ((r_state == S_WAIT) && !w_capture) r_wait_cnt <= r_wait_cnt - 1'b1;
      // A cancelled fetch leaves the previously delivered instruction visible
      if (w_capture) begin
        if (r_owner == OWN_MEM) r_mem_rdata <= bus.ram_rdata;
        else if (!r_kill_flag && !w_kill_hit) r_if_rdata <= bus.ram_rdata;
      end
      if (r_state == S_RESP) r_kill_flag <= 1'b0;
      else if (w_kill_hit)   r_kill_flag <= 1'b1;
    end
  end

  assign bus.if_ready  = (r_state == S_RESP) && (r_owner == OWN_IF) && !r_kill_flag && !bus.if_kill;
  assign bus.mem_ready = (r_state == S_RESP) && (r_owner == OWN_MEM);
  assign bus.if_stall  = bus.if_req && !bus.if_ready;
  assign bus.mem_stall = bus.mem_req && !bus.mem_ready;
  assign bus.if_rdata  = r_if_rdata;
  assign bus.mem_rdata = r_mem_rdata;
  assign bus.ram_en    = r_ram_en;
  assign bus.ram_we    = r_ram_we;
  assign bus.ram_addr  = r_ram_addr;
  assign bus.ram_wdata = r_ram_wdata;
  assign bus.ram_wstrb = r_ram_wstrb;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: one instance at MEM_LAT=1, one at MEM_LAT=3.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_mem_port_arbiter;
  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk = ~clk;

  mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) ia ();
  mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) ib ();

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(1), .STARVE_MAX(4))
    dut_a (.clk(clk), .rst(rst), .bus(ia.slave));
  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(3), .STARVE_MAX(4))
    dut_b (.clk(clk), .rst(rst), .bus(ib.slave));

  function automatic logic [31:0] ram_word(input logic [31:0] a);
    return (a == 32'h10) ? 32'h0050_0093 : {16'hC0DE, a[15:0]};
  endfunction

  // RAM models: data valid exactly MEM_LAT cycles after ram_en, garbage otherwise
  logic        a_v = 1'b0;
  logic [31:0] a_d = '0;
  always @(posedge clk) begin
    a_v <= ia.ram_en;
    a_d <= ram_word(ia.ram_addr);
  end
  assign ia.ram_rdata = a_v ? a_d : 32'hBAD0_BAD0;

  logic [2:0]  b_v = '0;
  logic [31:0] b_d0 = '0, b_d1 = '0, b_d2 = '0;
  always @(posedge clk) begin
    b_v  <= {b_v[1:0], ib.ram_en};
    b_d0 <= ram_word(ib.ram_addr);
    b_d1 <= b_d0;
    b_d2 <= b_d1;
  end
  assign ib.ram_rdata = b_v[2] ? b_d2 : 32'hBAD0_BAD0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1;
    ia.if_req = 0; ia.if_addr = '0; ia.if_kill = 0;
    ia.mem_req = 0; ia.mem_we = 0; ia.mem_addr = '0; ia.mem_wdata = '0; ia.mem_wstrb = '0;
    ib.if_req = 0; ib.if_addr = '0; ib.if_kill = 0;
    ib.mem_req = 0; ib.mem_we = 0; ib.mem_addr = '0; ib.mem_wdata = '0; ib.mem_wstrb = '0;
    repeat (3) cyc();

    // Reset state
    chk("rst_ram_en", ia.ram_en, 0);
    chk("rst_ram_we", ia.ram_we, 0);
    chk("rst_ram_addr", ia.ram_addr, 0);
    chk("rst_ram_wstrb", ia.ram_wstrb, 0);
    chk("rst_if_ready", ia.if_ready, 0);
    chk("rst_mem_ready", ia.mem_ready, 0);
    chk("rst_if_rdata", ia.if_rdata, 0);
    chk("rst_starve", dut_a.r_starve_cnt, 0);
    rst = 1'b0;
    cyc();

    // Single fetch, MEM_LAT=1
    ia.if_req = 1; ia.if_addr = 32'h10; #1;
    chk("t1_stall_c0", ia.if_stall, 1);
    chk("t1_en_c0", ia.ram_en, 0);
    cyc();
    chk("t1_en_c1", ia.ram_en, 1);
    chk("t1_addr_c1", ia.ram_addr, 32'h10);
    chk("t1_we_c1", ia.ram_we, 0);
    chk("t1_stall_c1", ia.if_stall, 1);
    cyc();
    chk("t1_en_c2", ia.ram_en, 0);
    chk("t1_ready_c2", ia.if_ready, 0);
    chk("t1_stall_c2", ia.if_stall, 1);
    cyc();
    chk("t1_ready_c3", ia.if_ready, 1);
    chk("t1_rdata_c3", ia.if_rdata, 32'h0050_0093);
    chk("t1_stall_c3", ia.if_stall, 0);
    ia.if_req = 0;
    cyc();
    chk("t1_ready_c4", ia.if_ready, 0);
    chk("t1_en_c4", ia.ram_en, 0);

    // Collision: MEM first, then IF
    ia.if_req = 1; ia.if_addr = 32'h20;
    ia.mem_req = 1; ia.mem_we = 0; ia.mem_addr = 32'h100;
    cyc();
    chk("t2_en_c1", ia.ram_en, 1);
    chk("t2_addr_c1", ia.ram_addr, 32'h100);
    chk("t2_wstrb_c1", ia.ram_wstrb, 0);
    cyc();
    cyc();
    chk("t2_mready_c3", ia.mem_ready, 1);
    chk("t2_mrdata_c3", ia.mem_rdata, 32'hC0DE_0100);
    chk("t2_iready_c3", ia.if_ready, 0);
    ia.mem_req = 0;
    cyc();
    chk("t2_mready_c4", ia.mem_ready, 0);
    chk("t2_en_c4", ia.ram_en, 0);
    cyc();
    chk("t2_en_c5", ia.ram_en, 1);
    chk("t2_addr_c5", ia.ram_addr, 32'h20);
    cyc();
    cyc();
    chk("t2_iready_c7", ia.if_ready, 1);
    chk("t2_irdata_c7", ia.if_rdata, 32'hC0DE_0020);
    ia.if_req = 0;
    cyc();

    // Starvation guard: four MEM grants, then IF wins
    ia.if_req = 1; ia.if_addr = 32'h30;
    ia.mem_req = 1; ia.mem_addr = 32'h100;
    for (int g = 0; g < 4; g++) begin
      cyc();
      chk("t3_mem_en", ia.ram_en, 1);
      chk("t3_mem_addr", ia.ram_addr, 32'h100 + 32'(4 * g));
      chk("t3_starve", dut_a.r_starve_cnt, 64'(g + 1));
      cyc();
      cyc();
      chk("t3_mready", ia.mem_ready, 1);
      chk("t3_istall", ia.if_stall, 1);
      ia.mem_addr = 32'h104 + 32'(4 * g);
      cyc();
    end
    cyc();
    chk("t3_if_en", ia.ram_en, 1);
    chk("t3_if_addr", ia.ram_addr, 32'h30);
    chk("t3_starve_clr", dut_a.r_starve_cnt, 0);
    chk("t3_mstall", ia.mem_stall, 1);
    cyc();
    cyc();
    chk("t3_iready", ia.if_ready, 1);
    chk("t3_irdata", ia.if_rdata, 32'hC0DE_0030);
    chk("t3_mready_no", ia.mem_ready, 0);
    ia.if_req = 0; ia.mem_req = 0;
    cyc();

    // Store, then a load with stale strobes on the bus
    ia.mem_req = 1; ia.mem_we = 1; ia.mem_addr = 32'h200;
    ia.mem_wdata = 32'hDEAD_BEEF; ia.mem_wstrb = 4'b0011;
    cyc();
    chk("t4_en_c1", ia.ram_en, 1);
    chk("t4_we_c1", ia.ram_we, 1);
    chk("t4_addr_c1", ia.ram_addr, 32'h200);
    chk("t4_wdata_c1", ia.ram_wdata, 32'hDEAD_BEEF);
    chk("t4_wstrb_c1", ia.ram_wstrb, 4'b0011);
    cyc();
    chk("t4_en_c2", ia.ram_en, 0);
    chk("t4_we_c2", ia.ram_we, 0);
    chk("t4_mready_c2", ia.mem_ready, 0);
    cyc();
    chk("t4_mready_c3", ia.mem_ready, 1);
    ia.mem_we = 0; ia.mem_addr = 32'h204;
    cyc();
    cyc();
    chk("t4_ld_en", ia.ram_en, 1);
    chk("t4_ld_we", ia.ram_we, 0);
    chk("t4_ld_wstrb", ia.ram_wstrb, 0);
    chk("t4_ld_addr", ia.ram_addr, 32'h204);
    cyc();
    cyc();
    chk("t4_ld_ready", ia.mem_ready, 1);
    chk("t4_ld_rdata", ia.mem_rdata, 32'hC0DE_0204);
    ia.mem_req = 0;
    cyc();

    // Kill during WAIT, MEM_LAT=3
    ib.if_req = 1; ib.if_addr = 32'h80;
    cyc();
    chk("t5_en_c1", ib.ram_en, 1);
    chk("t5_addr_c1", ib.ram_addr, 32'h80);
    cyc();
    ib.if_kill = 1; ib.if_req = 0;
    cyc();
    ib.if_kill = 0;
    chk("t5_ready_c3", ib.if_ready, 0);
    cyc();
    chk("t5_ready_c4", ib.if_ready, 0);
    cyc();
    chk("t5_ready_c5", ib.if_ready, 0);
    cyc();
    chk("t5_en_c6", ib.ram_en, 0);
    chk("t5_ready_c6", ib.if_ready, 0);
    ib.if_req = 1; ib.if_addr = 32'h40; ib.if_kill = 1;
    cyc();
    chk("t5_killidle_en", ib.ram_en, 0);
    ib.if_kill = 0;
    cyc();
    chk("t5_new_en", ib.ram_en, 1);
    chk("t5_new_addr", ib.ram_addr, 32'h40);
    cyc();
    cyc();
    cyc();
    chk("t5_new_early", ib.if_ready, 0);
    cyc();
    chk("t5_new_ready", ib.if_ready, 1);
    chk("t5_new_rdata", ib.if_rdata, 32'hC0DE_0040);
    ib.if_req = 0;
    cyc();

    // Reset in the middle of WAIT
    ib.mem_req = 1; ib.mem_we = 0; ib.mem_addr = 32'h300;
    cyc();
    chk("t6_en_c1", ib.ram_en, 1);
    cyc();
    rst = 1; ib.mem_req = 0;
    cyc();
    rst = 0;
    chk("t6_en_after", ib.ram_en, 0);
    chk("t6_mready_after", ib.mem_ready, 0);
    chk("t6_iready_after", ib.if_ready, 0);
    chk("t6_mrdata_after", ib.mem_rdata, 0);
    for (int k = 0; k < 4; k++) begin
      cyc();
      chk("t6_no_stale_ready", ib.mem_ready, 0);
      chk("t6_no_stale_rdata", ib.mem_rdata, 0);
    end
    ib.mem_req = 1; ib.mem_addr = 32'h304;
    cyc();
    chk("t6_post_en", ib.ram_en, 1);
    chk("t6_post_addr", ib.ram_addr, 32'h304);
    repeat (4) cyc();
    chk("t6_post_ready", ib.mem_ready, 1);
    chk("t6_post_rdata", ib.mem_rdata, 32'hC0DE_0304);
    ib.mem_req = 0;
    cyc();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
